dataflow_deadlock_monitor: RTL
==============================

// Module: dataflow_deadlock_monitor
// PURPOSE
//  Parametrised, synthesizable successor to the per-process deadlock detect units in the dataflow testbench.
//  - Input: a wait-for matrix across N_PROC dataflow processes. Bit i*N_PROC+j = process i blocked on
//    process j, through a FIFO or start-token channel.
//  - Waits for the matrix to be non-zero and stable for STALL_CYCLES cycles, then runs a hop-by-hop
//    reachability scan from each origin. It reports the first cycle it finds.
//  - Runs in silicon and in simulation: N general, stall filter, sticky report, clear/abort handling.
// PARAMETERS
//  N_PROC        4    number of monitored processes (>=2)
//  STALL_CYCLES  16   consecutive stable non-zero cycles required before a scan (>=2)
//  CNT_W         16   stall counter width; must hold STALL_CYCLES
//  IDX_W         localparam = $clog2(N_PROC)
// PORTS
//  clock       in   1             single clock; all state updates on rising edge
//  reset       in   1             synchronous, active-high
//  enable      in   1             0: force IDLE, counter 0; dl_* outputs hold their value
//  clear       in   1             1-cycle pulse: drop sticky report, return to IDLE
//  wait_vld    in   N_PROC*N_PROC wait-for matrix, row i = bits [i*N_PROC +: N_PROC]
//  dl_detect   out  1             sticky: deadlock cycle found
//  dl_origin   out  IDX_W         origin process of the reported cycle
//  dl_members  out  N_PROC        processes reachable from dl_origin at detection
//  scan_busy   out  1             high in LOAD/HOP/CHECK
//  scan_clean  out  1             1-cycle pulse: full scan completed, no cycle found
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; stall_cnt=0; wait_q=0.
//  wait_q registers wait_vld every cycle.
//  IDLE (only when enable=1 and dl_detect=0):
//   - If wait_vld!=0 and wait_vld==wait_q, stall_cnt increments; otherwise stall_cnt=0.
//   - On the edge where stall_cnt reaches STALL_CYCLES: snap<=wait_vld, org<=0, stall_cnt<=0, go LOAD.
//  LOAD, 1 cycle: reach<=row(snap,org); hop<=1; go HOP.
//  HOP, N_PROC-1 cycles: reach <= reach | OR over j where reach[j] of row(snap,j); hop++.
//   After hop N_PROC-1, go CHECK.
//  CHECK, 1 cycle:
//   - If reach[org]: dl_detect<=1, dl_origin<=org, dl_members<=reach, go IDLE.
//   - Else if org==N_PROC-1: pulse scan_clean, go IDLE.
//   - Else: org++, go LOAD.
//  Cost: N_PROC+1 cycles per origin. Every origin is scanned; origins with zero rows are not skipped.
//  Self-wait (bit i*N_PROC+i) counts as a cycle; it is found at CHECK of origin i.
//  Abort: in LOAD/HOP/CHECK, if wait_vld!=snap, go IDLE with stall_cnt=0. No report, no scan_clean.
//   The abort check has priority over CHECK results in the same cycle.
//  Sticky report: dl_detect=1 holds IDLE and freezes the counter until clear.
//  clear priority: reset > clear > enable=0 > FSM.
//   - clear zeroes dl_* and stall_cnt and forces IDLE, even mid-scan.
//   - If the deadlock persists, it is re-detected after STALL_CYCLES plus the scan.
//  enable=0 mid-scan aborts to IDLE. Reset mid-scan: reset values on the next edge.
//  Clean re-scan: after scan_clean, stall_cnt restarts at 0. An unchanged matrix re-scans
//   STALL_CYCLES later.
//  Latency, matrix first valid in cycle t0 and held:
//   - LOAD for origin 0 in t0+STALL_CYCLES+1.
//   - A cycle found at origin k raises dl_detect in t0+STALL_CYCLES+1+(k+1)*(N_PROC+1).
// TESTING  (N_PROC=4, STALL_CYCLES=16)
//  1 reset asserted mid-scan, then released with wait_vld=0 -> all outputs 0; no scan_busy for 100 cycles.
//  2 ring 0->1->3->0 (bits 1,7,12) held from t0 -> dl_detect=1 at t0+22, dl_origin=0,
//    dl_members=4'b1011; it stays high.
//  3 chain 0->1->2 (bits 1,6) held from t0 -> scan_clean pulse at t0+37, no dl_detect;
//    next pulse at t0+74.
//  4 ring as in 2, but bit 7 drops during HOP of origin 0 -> abort; scan_busy=0 next cycle;
//    no dl_detect, no scan_clean.
//  5 after 2, pulse clear with ring still held -> dl_* read 0 next cycle;
//    dl_detect returns 22 cycles after clear.
//  6 self-wait bit 10 (proc 2) only, held -> dl_origin=2, dl_members=4'b0100 at t0+32;
//    enable=0 repeat -> no activity.

Source files
------------

// File: rtl/dataflow_deadlock_monitor.sv
// Deadlock monitor for N_PROC dataflow processes: waits for a stable non-zero wait-for
// matrix, then walks reachability from each origin and reports the first cycle found.
module dataflow_deadlock_monitor #(
   parameter int N_PROC       = 4,
   parameter int STALL_CYCLES = 16,
   parameter int CNT_W        = 16,
   localparam int IDX_W       = $clog2(N_PROC)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       clear,
   input  logic [N_PROC*N_PROC-1:0]   wait_vld,
   output logic                       dl_detect,
   output logic [IDX_W-1:0]           dl_origin,
   output logic [N_PROC-1:0]          dl_members,
   output logic                       scan_busy,
   output logic                       scan_clean
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOP,
      ST_CHECK
   } state_t;

   state_t                     state_q, state_d;
   logic [N_PROC*N_PROC-1:0]   wait_q;
   logic [N_PROC*N_PROC-1:0]   snap_q, snap_d;
   logic [IDX_W-1:0]           org_q, org_d;
   logic [IDX_W-1:0]           hop_q, hop_d;
   logic [N_PROC-1:0]          reach_q, reach_d;
   logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
   logic                       dl_detect_q, dl_detect_d;
   logic [IDX_W-1:0]           dl_origin_q, dl_origin_d;
   logic [N_PROC-1:0]          dl_members_q, dl_members_d;
   logic                       scan_clean_q, scan_clean_d;
   logic [N_PROC-1:0]          hop_or;
   logic                       stable;
   logic                       abort;

   function automatic logic [N_PROC-1:0] row_of(input logic [N_PROC*N_PROC-1:0] m,
                                                input logic [IDX_W-1:0] i);
      return m[int'(i)*N_PROC +: N_PROC];
   endfunction

   // One hop: union of the rows of every process already reachable.
   always_comb begin
      hop_or = '0;
      for (int j = 0; j < N_PROC; j++) begin
         if (reach_q[j]) hop_or = hop_or | snap_q[j*N_PROC +: N_PROC];
      end
   end

   // Counting resumes only after the scan_clean pulse cycle, so a clean re-scan
   // of an unchanged matrix sits one full stall window plus one cycle behind.
   assign stable = (wait_vld != '0) && (wait_vld == wait_q) && !scan_clean_q;
   assign abort  = (wait_vld != snap_q);

   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      org_d        = org_q;
      hop_d        = hop_q;
      reach_d      = reach_q;
      stall_cnt_d  = stall_cnt_q;
      dl_detect_d  = dl_detect_q;
      dl_origin_d  = dl_origin_q;
      dl_members_d = dl_members_q;
      scan_clean_d = 1'b0;

      if (clear) begin
         state_d      = ST_IDLE;
         stall_cnt_d  = '0;
         dl_detect_d  = 1'b0;
         dl_origin_d  = '0;
         dl_members_d = '0;
      end else if (!enable) begin
         state_d     = ST_IDLE;
         stall_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!dl_detect_q) begin
                  if (stable) begin
                     if (stall_cnt_q == CNT_W'(STALL_CYCLES - 1)) begin
                        snap_d      = wait_vld;
                        org_d       = '0;
                        stall_cnt_d = '0;
                        state_d     = ST_LOAD;
                     end else begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                     end
                  end else begin
                     stall_cnt_d = '0;
                  end
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state_d     = ST_IDLE;
                  stall_cnt_d = '0;
               end else begin
                  reach_d = row_of(snap_q, org_q);
                  hop_d   = IDX_W'(1);
                  state_d = ST_HOP;
               end
            end
            ST_HOP: begin
               if (abort) begin
                  state_d     = ST_IDLE;
                  stall_cnt_d = '0;
               end else begin
                  reach_d = reach_q | hop_or;
                  if (hop_q == IDX_W'(N_PROC - 1)) begin
                     state_d = ST_CHECK;
                  end else begin
                     hop_d = hop_q + IDX_W'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (abort) begin
                  state_d     = ST_IDLE;
                  stall_cnt_d = '0;
               end else if (reach_q[org_q]) begin
                  dl_detect_d  = 1'b1;
                  dl_origin_d  = org_q;
                  dl_members_d = reach_q;
                  state_d      = ST_IDLE;
               end else if (org_q == IDX_W'(N_PROC - 1)) begin
                  scan_clean_d = 1'b1;
                  stall_cnt_d  = '0;
                  state_d      = ST_IDLE;
               end else begin
                  org_d   = org_q + IDX_W'(1);
                  state_d = ST_LOAD;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               stall_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_q       <= '0;
         snap_q       <= '0;
         org_q        <= '0;
         hop_q        <= '0;
         reach_q      <= '0;
         stall_cnt_q  <= '0;
         dl_detect_q  <= 1'b0;
         dl_origin_q  <= '0;
         dl_members_q <= '0;
         scan_clean_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_vld;
         snap_q       <= snap_d;
         org_q        <= org_d;
         hop_q        <= hop_d;
         reach_q      <= reach_d;
         stall_cnt_q  <= stall_cnt_d;
         dl_detect_q  <= dl_detect_d;
         dl_origin_q  <= dl_origin_d;
         dl_members_q <= dl_members_d;
         scan_clean_q <= scan_clean_d;
      end
   end

   assign dl_detect  = dl_detect_q;
   assign dl_origin  = dl_origin_q;
   assign dl_members = dl_members_q;
   assign scan_busy  = (state_q != ST_IDLE);
   assign scan_clean = scan_clean_q;

endmodule
